dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_CORES, default 4, meaning the number of cores sharing one data memory (legal range 2..8).
REQ-002 The module SHALL have parameter DATA_W, default 16, meaning the data and address width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req_rd, input, NUM_CORES bits: per-core level read request, held until ack.
REQ-006 The module SHALL have port req_wr, input, NUM_CORES bits: per-core level write request, held until ack.
REQ-007 The module SHALL have port core_addr, input, NUM_CORES*DATA_W bits: per-core address; core i occupies bits [i*DATA_W +: DATA_W].
REQ-008 The module SHALL have port core_wdata, input, NUM_CORES*DATA_W bits: per-core write data, packed the same way as core_addr.
REQ-009 The module SHALL have port ack, output, NUM_CORES bits: one-cycle completion pulse per core.
REQ-010 The module SHALL have port stall, output, NUM_CORES bits: hold request to the core clock corrector, combinational (req_rd|req_wr) & ~ack per core.
REQ-011 The module SHALL have port rdata, output, DATA_W bits: registered read data, broadcast to all cores.
REQ-012 The module SHALL have ports mem_addr (output, DATA_W), mem_wdata (output, DATA_W), mem_we (output, 1), mem_re (output, 1) and mem_rdata (input, DATA_W) forming the single-port memory side; memory read latency is 1 cycle.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and DONE.
REQ-014 In IDLE, when any request is pending, the module SHALL select the first requesting core at or after rr_ptr (modulo NUM_CORES), latch its index, address, wdata and op, then enter ISSUE.
REQ-015 If a core asserts req_rd and req_wr together, the module SHALL treat it as a write.
REQ-016 In ISSUE, the module SHALL drive mem_addr/mem_wdata from the latched values and assert exactly one of mem_we or mem_re for exactly one cycle; a write SHALL go to DONE and a read SHALL go to CAPTURE.
REQ-017 In CAPTURE, the module SHALL register mem_rdata into rdata and go to DONE.
REQ-018 In DONE, the module SHALL pulse ack[idx] for 1 cycle, set rr_ptr to idx+1 (wrapping NUM_CORES-1 to 0), and return to IDLE.
REQ-019 Latency SHALL be measured from the edge at which IDLE samples the request to the ack pulse: a write SHALL take 3 cycles and a read SHALL take 4 cycles.
REQ-020 rdata SHALL hold its value until the next read capture.
REQ-021 mem_we, mem_re and ack SHALL be registered outputs that are glitch-free.
REQ-022 If the granted core drops its request mid-transaction, the module SHALL still complete the transaction and still pulse ack.
REQ-023 A request still high in the cycle after ack SHALL be treated as a new request and arbitrated normally; because rr_ptr has advanced, other pending cores win first.
REQ-024 Requests arriving while not in IDLE SHALL wait; no request SHALL be lost or reordered within a core.

Reset
REQ-025 While RESET_N is low, the FSM SHALL be in IDLE, rr_ptr SHALL be 0, ack SHALL be 0, mem_we and mem_re SHALL be 0, and mem_addr, mem_wdata and rdata SHALL be 0.
REQ-026 On a reset asserted mid-transaction, the module SHALL abort the transaction immediately, SHALL NOT complete a pending write, and SHALL issue no ack.

Configuration
REQ-027 When macro DMEM_ARBITER_PERF_EN is defined, the module SHALL add output conflict_cnt (16 bits, reset 0), which increments by 1 per cycle in which at least one core has stall=1 while a different core holds the grant, saturating at 16'hFFFF.
REQ-028 When DMEM_ARBITER_PERF_EN is not defined, the port and counter SHALL be absent, and behaviour SHALL otherwise be identical.

Verification
REQ-029 The bench SHALL drive core 1 req_wr with addr 0x0010 and wdata 0xABCD: mem_we SHALL pulse once with addr 0x0010 and data 0xABCD, and ack[1] SHALL pulse 3 cycles after sampling.
REQ-030 The bench SHALL drive core 2 req_rd at addr 0x0005 with the memory holding 0x1234: rdata SHALL be 0x1234 when ack[2] pulses, 4 cycles after sampling.
REQ-031 The bench SHALL hold all four cores requesting continuously from reset: grants SHALL go in the order 0,1,2,3,0, with ack spacing of 4 cycles for reads.
REQ-032 The bench SHALL drive core 3 with req_rd and req_wr both high: exactly one mem_we pulse and no mem_re SHALL occur.
REQ-033 The bench SHALL assert RESET_N low during ISSUE of a write: mem_we SHALL be 0, no ack SHALL occur, and after release core 0 SHALL win first.
REQ-034 With DMEM_ARBITER_PERF_EN defined and 2 cores reading concurrently for one transaction, conflict_cnt SHALL read 4 after the first ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Round-robin arbiter that lets NUM_CORES cores share one single-port data
// memory. Each core holds a level read or write request until it receives a
// one-cycle ack. A core that asserts read and write together is served as a
// write. The transaction sequence is IDLE -> ISSUE -> (CAPTURE) -> DONE.
// Counting the IDLE cycle in which the request is sampled, a write acks in
// its 3rd cycle and a read acks in its 4th. The ack is high during DONE, so a
// request still high in the following IDLE cycle is a new request.
//
// Parameters
//   NUM_CORES  number of cores sharing the memory (2..8)
//   DATA_W     data and address width
//
// Ports
//   clk           clock, rising edge
//   RESET_N       asynchronous active-low reset
//   req_rd        per-core read request (level)
//   req_wr        per-core write request (level)
//   core_addr     per-core address, core i at [i*DATA_W +: DATA_W]
//   core_wdata    per-core write data, packed like core_addr
//   ack           per-core one-cycle completion pulse (registered)
//   stall         per-core hold request: (req_rd | req_wr) & ~ack
//   rdata         registered read data, broadcast to all cores
//   mem_addr      memory address
//   mem_wdata     memory write data
//   mem_we        memory write strobe (registered, one cycle)
//   mem_re        memory read strobe (registered, one cycle)
//   mem_rdata     memory read data, valid one cycle after mem_re
//   conflict_cnt  (DMEM_ARBITER_PERF_EN only) saturating count of cycles in
//                 which some core stalls while a different core holds the
//                 grant
//
// Build option
//   DMEM_ARBITER_PERF_EN  adds the conflict_cnt output and its counter.
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | arbitrate; latch winner's index, address, data and op
//   ISSUE    | mem_we or mem_re high for this single cycle
//   CAPTURE  | mem_rdata is valid; register it into rdata
//   DONE     | ack[idx] high; advance rr_ptr past idx
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        RESET_N,
    input  logic [NUM_CORES-1:0]        req_rd,
    input  logic [NUM_CORES-1:0]        req_wr,
    input  logic [NUM_CORES*DATA_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [NUM_CORES-1:0]        stall,
    output logic [DATA_W-1:0]           rdata,
    output logic [DATA_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    output logic                        mem_re,
    input  logic [DATA_W-1:0]           mem_rdata
`ifdef DMEM_ARBITER_PERF_EN
    ,
    output logic [15:0]                 conflict_cnt
`endif
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic [IDX_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [DATA_W-1:0]     addr_q,    addr_d;
    logic [DATA_W-1:0]     wdata_q,   wdata_d;
    logic                  is_wr_q,   is_wr_d;
    logic                  mem_we_q,  mem_we_d;
    logic                  mem_re_q,  mem_re_d;
    logic [NUM_CORES-1:0]  ack_q,     ack_d;
    logic [DATA_W-1:0]     rdata_q,   rdata_d;

    logic [NUM_CORES-1:0]  pending;
    logic                  any_req;
    logic [IDX_W-1:0]      win_idx;
    logic [DATA_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  sel_wr;

    assign pending = req_rd | req_wr;

    // First requesting core at or after rr_ptr, wrapping modulo NUM_CORES.
    always_comb begin
        int cand;
        cand    = 0;
        any_req = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            if (!any_req && pending[cand]) begin
                any_req = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    // Mux the winner's address, data and op. A simultaneous read+write
    // request resolves to a write because only req_wr is consulted.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (win_idx == IDX_W'(k)) begin
                sel_addr  = core_addr[k*DATA_W +: DATA_W];
                sel_wdata = core_wdata[k*DATA_W +: DATA_W];
                sel_wr    = req_wr[k];
            end
        end
    end

    // Strobes and ack are computed one state ahead so that the registered
    // versions line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        is_wr_d  = is_wr_q;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        ack_d    = '0;
        rdata_d  = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    idx_d    = win_idx;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    is_wr_d  = sel_wr;
                    mem_we_d = sel_wr;
                    mem_re_d = ~sel_wr;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_wr_q) begin
                    ack_d[idx_q] = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    state_d      = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rdata_d      = mem_rdata;
                ack_d[idx_q] = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (idx_q == IDX_W'(NUM_CORES - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = idx_q + IDX_W'(1);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            is_wr_q  <= 1'b0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            is_wr_q  <= is_wr_d;
            mem_we_q <= mem_we_d;
            mem_re_q <= mem_re_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign stall     = pending & ~ack_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

`ifdef DMEM_ARBITER_PERF_EN
    // The grant belongs to the arbitration winner during a sampling IDLE
    // cycle and to the latched index for the rest of the transaction.
    logic [15:0]          conflict_cnt_q, conflict_cnt_d;
    logic                 grant_vld;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_CORES-1:0] other_stall;
    logic                 conflict;

    always_comb begin
        grant_vld   = (state_q != S_IDLE) || any_req;
        grant_idx   = (state_q == S_IDLE) ? win_idx : idx_q;
        other_stall = stall;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                other_stall[k] = 1'b0;
            end
        end
        conflict       = grant_vld && (|other_stall);
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
